// File: rtl/arb_pkg.sv
// arb_pkg: shared types and helpers for the round-robin hold arbiter.
// Provides the FSM state enum and a one-hot to index conversion.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned ARB_OH_MAX = 64;

  // OR of the set-bit positions; exact for one-hot or zero input.
  function automatic int unsigned oh2idx(
    input logic [ARB_OH_MAX-1:0] oh
  );
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < ARB_OH_MAX; i++) begin
      if (oh[i]) idx |= i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: combinational round-robin winner select.
// Ports: req (N), ptr (IDW) in; win (one-hot N), win_id (IDW) out.
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter int N = 8,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   win,
  output logic [IDW-1:0] win_id
);

  localparam int DW = 2 * N;

  logic [DW-1:0] msk;
  logic [DW-1:0] dbl;
  logic [DW-1:0] low;

  // Upper copy covers the wrapped part 0..ptr-1.
  always_comb begin
    msk    = ~((DW'(1) << ptr) - DW'(1));
    dbl    = {req, req} & msk;
    low    = dbl & (~dbl + DW'(1));
    win    = low[N-1:0] | low[DW-1:N];
    win_id = IDW'(oh2idx(ARB_OH_MAX'(win)));
  end

endmodule

// File: rtl/arb_rr_hold.sv
// arb_rr_hold: N-way round-robin arbiter, registered grant held until done.
// Ports: clk, rst (async high), req_i/ack_i upstream, req_o/ack_o downstream,
// gnt_vld_o, gnt_id_o; lock_i burst lock exists only with ARB_LOCK_EN.
module arb_rr_hold
  import arb_pkg::*;
#(
  parameter int N = 8,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_i,
  output logic [N-1:0]   ack_i,
  output logic           req_o,
  input  logic           ack_o,
  output logic           gnt_vld_o,
  output logic [IDW-1:0] gnt_id_o
`ifdef ARB_LOCK_EN
  ,
  input  logic [N-1:0]   lock_i
`endif
);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [N-1:0]   gnt_q, gnt_d;

  logic [N-1:0]   pick_win;
  logic [IDW-1:0] pick_id;
  logic [IDW-1:0] ptr_inc;
  logic           cur_req;
  logic           done;
  logic           lock_hold;

  arb_rr_pick #(.N(N)) u_pick (
    .req    (req_i),
    .ptr    (ptr_q),
    .win    (pick_win),
    .win_id (pick_id)
  );

  assign cur_req = req_i[id_q];
  assign done    = (state_q == ARB_BUSY) & cur_req & ack_o;
  assign ptr_inc = (id_q == IDW'(N - 1)) ? '0 : id_q + IDW'(1);

`ifdef ARB_LOCK_EN
  assign lock_hold = lock_i[id_q];
`else
  assign lock_hold = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (|req_i) begin
          state_d = ARB_BUSY;
          gnt_d   = pick_win;
          id_d    = pick_id;
        end
      end
      ARB_BUSY: begin
        // Withdraw or unlocked completion releases; locked beats stay.
        if (!cur_req || (done && !lock_hold)) begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_inc;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_comb begin
    gnt_vld_o = (state_q == ARB_BUSY);
    req_o     = gnt_vld_o & cur_req;
    ack_i     = gnt_q & {N{req_o & ack_o}};
    gnt_id_o  = id_q;
  end

endmodule

// File: tb/tb_arb_rr_hold.sv
// tb_arb_rr_hold: directed vector bench for arb_rr_hold at N=4.
// Table of {inputs, expected outputs} plus reset and lock sequences.
module tb_arb_rr_hold;

  localparam int N = 4;

  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic [3:0] lock;
    logic       vld;
    logic [1:0] id;
    logic       reqo;
    logic [3:0] acki;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_i = '0;
  logic [3:0] ack_i;
  logic       req_o;
  logic       ack_o = 1'b0;
  logic       gnt_vld_o;
  logic [1:0] gnt_id_o;
  logic [3:0] lock_i = '0;

  int n_vec = 0;
  int n_bad = 0;

  vec_t tbl[$];

  always #5 clk = ~clk;

  arb_rr_hold #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .ack_i     (ack_i),
    .req_o     (req_o),
    .ack_o     (ack_o),
    .gnt_vld_o (gnt_vld_o),
`ifdef ARB_LOCK_EN
    .gnt_id_o  (gnt_id_o),
    .lock_i    (lock_i)
`else
    .gnt_id_o  (gnt_id_o)
`endif
  );

  function automatic vec_t mk(
    input logic [3:0] req, input logic ack, input logic [3:0] lock,
    input logic vld, input logic [1:0] id, input logic reqo,
    input logic [3:0] acki
  );
    vec_t v;
    v.req = req; v.ack = ack; v.lock = lock;
    v.vld = vld; v.id = id; v.reqo = reqo; v.acki = acki;
    return v;
  endfunction

  task automatic check(input string name, input logic vld,
    input logic [1:0] id, input logic reqo, input logic [3:0] acki);
    logic [7:0] got, exp;
    got = {gnt_vld_o, gnt_id_o, req_o, ack_i};
    exp = {vld, id, reqo, acki};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got vld=%b id=%0d req_o=%b ack_i=%b, want vld=%b id=%0d req_o=%b ack_i=%b",
        name, gnt_vld_o, gnt_id_o, req_o, ack_i, vld, id, reqo, acki);
    end
  endtask

  // Drive in mid-cycle, check settled outputs, then cross one edge.
  task automatic apply(input string name, input vec_t v);
    req_i  = v.req;
    ack_o  = v.ack;
    lock_i = v.lock;
    #2;
    check(name, v.vld, v.id, v.reqo, v.acki);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset then idle
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(4'b0000, 1'b0, 4'b0, 1'b0, 2'd0, 1'b0, 4'b0000));
    // single requester 2
    tbl.push_back(mk(4'b0100, 1'b1, 4'b0, 1'b0, 2'd0, 1'b0, 4'b0000));
    tbl.push_back(mk(4'b0100, 1'b1, 4'b0, 1'b1, 2'd2, 1'b1, 4'b0100));
    tbl.push_back(mk(4'b0000, 1'b1, 4'b0, 1'b0, 2'd2, 1'b0, 4'b0000));
    // all requesting from ptr=3: 3,0,1,2,3,0
    tbl.push_back(mk(4'b1111, 1'b1, 4'b0, 1'b0, 2'd2, 1'b0, 4'b0000));
    tbl.push_back(mk(4'b1111, 1'b1, 4'b0, 1'b1, 2'd3, 1'b1, 4'b1000));
    tbl.push_back(mk(4'b1111, 1'b1, 4'b0, 1'b0, 2'd3, 1'b0, 4'b0000));
    tbl.push_back(mk(4'b1111, 1'b1, 4'b0, 1'b1, 2'd0, 1'b1, 4'b0001));
    tbl.push_back(mk(4'b1111, 1'b1, 4'b0, 1'b0, 2'd0, 1'b0, 4'b0000));
    tbl.push_back(mk(4'b1111, 1'b1, 4'b0, 1'b1, 2'd1, 1'b1, 4'b0010));
    tbl.push_back(mk(4'b1111, 1'b1, 4'b0, 1'b0, 2'd1, 1'b0, 4'b0000));
    tbl.push_back(mk(4'b1111, 1'b1, 4'b0, 1'b1, 2'd2, 1'b1, 4'b0100));
    tbl.push_back(mk(4'b1111, 1'b1, 4'b0, 1'b0, 2'd2, 1'b0, 4'b0000));
    tbl.push_back(mk(4'b1111, 1'b1, 4'b0, 1'b1, 2'd3, 1'b1, 4'b1000));
    tbl.push_back(mk(4'b1111, 1'b1, 4'b0, 1'b0, 2'd3, 1'b0, 4'b0000));
    tbl.push_back(mk(4'b1111, 1'b1, 4'b0, 1'b1, 2'd0, 1'b1, 4'b0001));
    // stall grant 1, then withdraw with ack_o high
    tbl.push_back(mk(4'b0010, 1'b0, 4'b0, 1'b0, 2'd0, 1'b0, 4'b0000));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(4'b0010, 1'b0, 4'b0, 1'b1, 2'd1, 1'b1, 4'b0000));
    tbl.push_back(mk(4'b0101, 1'b1, 4'b0, 1'b1, 2'd1, 1'b0, 4'b0000));
    tbl.push_back(mk(4'b0101, 1'b0, 4'b0, 1'b0, 2'd1, 1'b0, 4'b0000));
    tbl.push_back(mk(4'b0101, 1'b1, 4'b0, 1'b1, 2'd2, 1'b1, 4'b0100));
    // grant 3 completes, wraps to ptr=0
    tbl.push_back(mk(4'b1000, 1'b0, 4'b0, 1'b0, 2'd2, 1'b0, 4'b0000));
    tbl.push_back(mk(4'b1000, 1'b1, 4'b0, 1'b1, 2'd3, 1'b1, 4'b1000));
    tbl.push_back(mk(4'b1001, 1'b0, 4'b0, 1'b0, 2'd3, 1'b0, 4'b0000));
    tbl.push_back(mk(4'b1001, 1'b1, 4'b0, 1'b1, 2'd0, 1'b1, 4'b0001));
    // ptr=1 now; 3 wins, then hold it stalled
    tbl.push_back(mk(4'b1000, 1'b0, 4'b0, 1'b0, 2'd0, 1'b0, 4'b0000));
    tbl.push_back(mk(4'b1000, 1'b0, 4'b0, 1'b1, 2'd3, 1'b1, 4'b0000));

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // async reset mid-BUSY, no edge in between
    req_i = 4'b1000;
    ack_o = 1'b1;
    #2;
    check("pre_rst_ack", 1'b1, 2'd3, 1'b1, 4'b1000);
    rst = 1'b1;
    #1;
    check("async_rst", 1'b0, 2'd0, 1'b0, 4'b0000);
    @(posedge clk);
    #1;
    check("rst_hold", 1'b0, 2'd0, 1'b0, 4'b0000);
    rst = 1'b0;

    // ptr back at 0: 1001 must pick 0, not 3
    apply("post_rst_idle", mk(4'b1001, 1'b0, 4'b0, 1'b0, 2'd0, 1'b0, 4'b0000));
    apply("post_rst_gnt", mk(4'b1001, 1'b0, 4'b0, 1'b1, 2'd0, 1'b1, 4'b0000));

`ifdef ARB_LOCK_EN
    for (int b = 0; b < 3; b++)
      apply($sformatf("lock_beat%0d", b),
        mk(4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b0001));
    apply("lock_last", mk(4'b1001, 1'b1, 4'b1000, 1'b1, 2'd0, 1'b1, 4'b0001));
`else
    apply("nolock_beat", mk(4'b1001, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1, 4'b0001));
`endif
    apply("after_burst", mk(4'b1001, 1'b0, 4'b0, 1'b0, 2'd0, 1'b0, 4'b0000));
    apply("next_gnt3", mk(4'b1001, 1'b0, 4'b0, 1'b1, 2'd3, 1'b1, 4'b0000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
